// File: rtl/minimips_defs.sv
// rtl/minimips_defs.sv - shared MiniMIPS datapath constants and multiplier state encoding
//
// Contents:
//   WIDTH         operand width of the datapath
//   CNT_W         multiplier iteration counter width (2**CNT_W == WIDTH)
//   DONE_LATENCY  cycles from an accepted start to the done pulse
//   mult_state_e  multiplier FSM states (IDLE / RUN / DONE)
package minimips_defs;

  localparam int WIDTH        = 32;
  localparam int CNT_W        = 5;
  localparam int DONE_LATENCY = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/adder_32bit.sv
// rtl/adder_32bit.sv - ripple-carry adder shared by the sequential multiplier
//
// Ports:
//   a, b       addend operands
//   carry_in   carry into bit 0
//   sum        WIDTH-bit sum
//   carry_out  carry out of the top bit
module adder_32bit
  import minimips_defs::*;
#(
  parameter int WIDTH = minimips_defs::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  logic carry;

  // Bit-serial carry propagation, one full adder per bit.
  always_comb begin
    sum   = '0;
    carry = carry_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    carry_out = carry;
  end

endmodule

// File: rtl/mult_32bit_seq.sv
// rtl/mult_32bit_seq.sv - sequential unsigned shift-add multiplier with start/busy/done handshake
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   start  request a multiply (accepted in IDLE or DONE)
//   a, b   multiplicand / multiplier, captured on acceptance
//   busy   high while iterating (RUN)
//   done   one-cycle pulse, hi/lo hold the product
//   hi, lo upper / lower halves of the 2*WIDTH-bit product
module mult_32bit_seq
  import minimips_defs::*;
#(
  parameter int WIDTH = minimips_defs::WIDTH,
  parameter int CNT_W = minimips_defs::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept;
  logic             last_iter;

  // The multiplier LSB sits in lo[0]; it selects whether mcand is added this step.
  assign addend    = lo_q[0] ? mcand_q : '0;
  assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last_iter = (count_q == LastCount);

  adder_32bit #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a        (hi_q),
    .b        (addend),
    .carry_in (1'b0),
    .sum      (sum),
    .carry_out(carry)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load on acceptance, shift-add while running, hold otherwise.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    count_d = count_q;
    if (accept) begin
      mcand_d = a;
      hi_d    = '0;
      lo_d    = b;
      count_d = '0;
    end else if (state_q == ST_RUN) begin
      // {carry, sum, lo} shifted right by one: product bits drain into lo
      // while the consumed multiplier bits fall off the bottom.
      hi_d    = {carry, sum[WIDTH-1:1]};
      lo_d    = {sum[0], lo_q[WIDTH-1:1]};
      // Natural wrap returns the counter to 0 on the last iteration.
      count_d = count_q + 1'b1;
    end
  end

  // Outputs.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_32bit_seq.sv
// tb/tb_mult_32bit_seq.sv - self-checking bench for mult_32bit_seq
module tb_mult_32bit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb[$];
  logic        prev_done = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  mult_32bit_seq dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a_in),
    .b    (b_in),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
    end
  endtask

  // Scoreboard and protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("busy_and_done_exclusive", 64'(busy & done), 64'd0);
      if (done) begin
        check("done_single_cycle", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          check("product", {hi, lo}, sb.pop_front());
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Issues one operation, drops start after acceptance and waits for done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int lat;
    int busy_cycles;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    lat   = 1;
    busy_cycles = 0;
    check("busy_after_accept", 64'(busy), 64'd1);
    while (!done && lat < 60) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check("done_latency", 64'(lat), 64'd33);
    check("busy_cycles", 64'(busy_cycles), 64'd32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
    vecs[3] = '{32'h1234_5678, 32'd0, 64'd0};
    vecs[4] = '{32'd0, 32'hDEAD_BEEF, 64'd0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table, each followed by a hold check on hi/lo.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        check("hold_after_done", {hi, lo}, vecs[i].p);
      end
    end

    // Back-to-back with start held high; a/b scrambled during RUN.
    @(negedge clk);
    a_in  = 32'd7;
    b_in  = 32'd6;
    start = 1'b1;
    sb.push_back(64'd42);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done) begin
        a_in = $urandom;
        b_in = $urandom;
      end
    end while (!done && lat < 60);
    check("b2b_first_latency", 64'(lat), 64'd33);
    a_in = 32'd9;
    b_in = 32'd9;
    sb.push_back(64'd81);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("b2b_second_accept", 64'(busy), 64'd1);
      start = ((lat % 4) == 0) && (lat < 28);
      a_in  = $urandom;
      b_in  = $urandom;
    end while (!done && lat < 60);
    check("b2b_second_latency", 64'(lat), 64'd33);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous abort mid-RUN.
    a_in  = 32'h0000_FFFF;
    b_in  = 32'h0000_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("no_done_after_abort", 64'(done), 64'd0);
    end
    run_op(32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001);

    // Random regression against a 64-bit reference product.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) ra = 32'hFFFF_FFFF;
      run_op(ra, rb, 64'(ra) * 64'(rb));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
